// File: rtl/mem_result_checker_if.sv
// rtl/mem_result_checker_if.sv - data-bus snoop, expected-table load and result signals of mem_result_checker
// EXP_MASK exists only when CHECKER_MASK_EN is defined.
interface mem_result_checker_if #(
    parameter int NUM_CHECKS = 14,
    parameter int IW         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
);
    logic          DREQ;
    logic          DRW;
    logic [31:0]   DADDR;
    logic [1:0]    DSIZE;
    logic [31:0]   DOUT;
    logic          EXP_WE;
    logic [IW-1:0] EXP_IDX;
    logic [31:0]   EXP_DATA;
`ifdef CHECKER_MASK_EN
    logic [31:0]   EXP_MASK;
`endif
    logic          DONE;
    logic          PASS;
    logic [IW:0]   FAIL_CNT;
    logic [IW-1:0] FIRST_FAIL;
    logic [31:0]   FIRST_GOT;
    logic          ERR;

    modport master (
        output DREQ, DRW, DADDR, DSIZE, DOUT, EXP_WE, EXP_IDX, EXP_DATA,
`ifdef CHECKER_MASK_EN
        output EXP_MASK,
`endif
        input  DONE, PASS, FAIL_CNT, FIRST_FAIL, FIRST_GOT, ERR
    );

    modport slave (
        input  DREQ, DRW, DADDR, DSIZE, DOUT, EXP_WE, EXP_IDX, EXP_DATA,
`ifdef CHECKER_MASK_EN
        input  EXP_MASK,
`endif
        output DONE, PASS, FAIL_CNT, FIRST_FAIL, FIRST_GOT, ERR
    );
endinterface

// File: rtl/mem_result_checker.sv
// rtl/mem_result_checker.sv - passive data-bus snooper that captures a result window and checks it against an expected table
// Define CHECKER_MASK_EN to add a per-slot compare mask table loaded through EXP_MASK.
module mem_result_checker #(
    parameter int          NUM_CHECKS = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0210,
    parameter int          TIMEOUT    = 9500,
    parameter int          IW         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    mem_result_checker_if.slave  bus
);
    localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(TIMEOUT - 1);
    localparam logic [31:0]   WIN_BYTES = 32'(4 * NUM_CHECKS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CHECKS - 1);

    typedef enum logic [1:0] {ARM, CHECK, FIN} state_t;

    state_t          state;
    logic [CW-1:0]   cyc_cnt;
    logic [IW-1:0]   chk_idx;
    logic [IW:0]     fail_acc;
    logic [IW-1:0]   ff_idx;
    logic [31:0]     ff_got;
    logic [NUM_CHECKS-1:0] written;
    logic [31:0]     cap     [NUM_CHECKS];
    logic [31:0]     exp_tab [NUM_CHECKS];
`ifdef CHECKER_MASK_EN
    logic [31:0]     mask_tab [NUM_CHECKS];
`endif

    // Snoop decode: window hit, slot index and SRAM-style byte lanes.
    logic [31:0]     offset;
    logic            in_win;
    logic [IW-1:0]   slot;
    logic [3:0]      lane_en;
    logic            align_ok;
    logic            snoop;
    logic            cap_we;
    logic            err_set;
    logic [NUM_CHECKS-1:0] written_next;
    logic            all_written;
    logic            timeout_hit;

    assign offset = bus.DADDR - BASE_ADDR;
    assign in_win = (bus.DADDR >= BASE_ADDR) && (offset < WIN_BYTES);
    assign slot   = offset[IW+1:2];

    always_comb begin
        lane_en  = 4'b0000;
        align_ok = 1'b0;
        case (bus.DSIZE)
            2'b00: begin
                lane_en  = 4'b0001 << bus.DADDR[1:0];
                align_ok = 1'b1;
            end
            2'b01: begin
                if (bus.DADDR[1:0] == 2'b00) begin
                    lane_en  = 4'b0011;
                    align_ok = 1'b1;
                end else if (bus.DADDR[1:0] == 2'b10) begin
                    lane_en  = 4'b1100;
                    align_ok = 1'b1;
                end
            end
            2'b10: begin
                if (bus.DADDR[1:0] == 2'b00) begin
                    lane_en  = 4'b1111;
                    align_ok = 1'b1;
                end
            end
            default: begin
                lane_en  = 4'b0000;
                align_ok = 1'b0;
            end
        endcase
    end

    assign snoop   = (state == ARM) && bus.DREQ && bus.DRW && in_win;
    assign cap_we  = snoop && align_ok;
    assign err_set = snoop && !align_ok;

    always_comb begin
        written_next = written;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (cap_we && (slot == IW'(i))) begin
                written_next[i] = 1'b1;
            end
        end
    end

    assign all_written = &written_next;
    assign timeout_hit = (cyc_cnt == CYC_LAST);

    // Compare path for the slot visited this cycle.
    logic [31:0] chk_got;
    logic [31:0] chk_exp;
    logic [31:0] chk_mask;
    logic        slot_fail;
    logic        first_here;

    assign chk_got = cap[chk_idx];
    assign chk_exp = exp_tab[chk_idx];
`ifdef CHECKER_MASK_EN
    assign chk_mask = mask_tab[chk_idx];
`else
    assign chk_mask = 32'hFFFF_FFFF;
`endif
    assign slot_fail  = !written[chk_idx] || (((chk_got ^ chk_exp) & chk_mask) != 32'h0);
    assign first_here = slot_fail && (fail_acc == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ARM;
            cyc_cnt        <= '0;
            chk_idx        <= '0;
            fail_acc       <= '0;
            ff_idx         <= '0;
            ff_got         <= '0;
            written        <= '0;
            bus.DONE       <= 1'b0;
            bus.PASS       <= 1'b0;
            bus.FAIL_CNT   <= '0;
            bus.FIRST_FAIL <= '0;
            bus.FIRST_GOT  <= '0;
            bus.ERR        <= 1'b0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                cap[i]      <= '0;
                exp_tab[i]  <= '0;
`ifdef CHECKER_MASK_EN
                mask_tab[i] <= 32'hFFFF_FFFF;
`endif
            end
        end else begin
            // The table stays writable during the sweep; slots not yet visited see the new value.
            if (bus.EXP_WE && ({1'b0, bus.EXP_IDX} < (IW+1)'(NUM_CHECKS))) begin
                exp_tab[bus.EXP_IDX]  <= bus.EXP_DATA;
`ifdef CHECKER_MASK_EN
                mask_tab[bus.EXP_IDX] <= bus.EXP_MASK;
`endif
            end

            case (state)
                ARM: begin
                    if (cap_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (lane_en[b]) begin
                                cap[slot][8*b +: 8] <= bus.DOUT[8*b +: 8];
                            end
                        end
                    end
                    written <= written_next;
                    if (err_set) begin
                        bus.ERR <= 1'b1;
                    end
                    if (all_written || timeout_hit) begin
                        state   <= CHECK;
                        chk_idx <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                CHECK: begin
                    if (slot_fail) begin
                        fail_acc <= fail_acc + (IW+1)'(1);
                    end
                    if (first_here) begin
                        ff_idx <= chk_idx;
                        ff_got <= chk_got;
                    end
                    // Results are published in one step so DONE, PASS and FAIL_CNT move together.
                    if (chk_idx == LAST_IDX) begin
                        state          <= FIN;
                        bus.DONE       <= 1'b1;
                        bus.FAIL_CNT   <= fail_acc + (IW+1)'(slot_fail);
                        bus.PASS       <= (fail_acc == '0) && !slot_fail && !bus.ERR;
                        bus.FIRST_FAIL <= first_here ? chk_idx : ff_idx;
                        bus.FIRST_GOT  <= first_here ? chk_got : ff_got;
                    end else begin
                        chk_idx <= chk_idx + IW'(1);
                    end
                end

                default: begin
                    state <= FIN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_result_checker.sv
// tb/tb_mem_result_checker.sv - directed bench for mem_result_checker with a slot-level reference model
module tb_mem_result_checker;
    localparam int          NUM  = 14;
    localparam int          IW   = 4;
    localparam logic [31:0] BASE = 32'h0000_0210;
    localparam int          TO   = 100;

    logic CLK;
    logic RESET;
    int   n_tests;
    int   n_fail;

    mem_result_checker_if #(.NUM_CHECKS(NUM)) bif ();

    mem_result_checker #(
        .NUM_CHECKS (NUM),
        .BASE_ADDR  (BASE),
        .TIMEOUT    (TO)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_got  [NUM];
    logic [31:0] m_exp  [NUM];
    logic [31:0] m_mask [NUM];
    bit          m_wr   [NUM];
    bit          m_err;
    int          m_edges;
    int          m_done_edge;
    int          m_phase;
    int          m_slot;
    int          m_fcnt;
    int          m_ff;
    logic [31:0] m_fg;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    endfunction

    function automatic bit legal(input logic [1:0] sz, input logic [1:0] off);
        int n = nbytes(sz);
        return (n != 0) && ((int'(off) % n) == 0);
    endfunction

    function automatic logic [31:0] merged(input logic [31:0] old, input logic [31:0] d,
                                           input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r = old;
        for (int k = 0; k < nbytes(sz); k++) r[8*(int'(off)+k) +: 8] = d[8*(int'(off)+k) +: 8];
        return r;
    endfunction

    function automatic int slot_of(input logic [31:0] a);
        if (longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 4*NUM)
            return int'((a - BASE) / 4);
        return -1;
    endfunction

    function automatic bit bus_write();
        return bif.DREQ && bif.DRW && (slot_of(bif.DADDR) >= 0);
    endfunction

    function automatic bit full_after();
        bit now = bus_write() && legal(bif.DSIZE, bif.DADDR[1:0]);
        for (int i = 0; i < NUM; i++)
            if (!(m_wr[i] || (now && slot_of(bif.DADDR) == i))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit slot_fails(input int s);
        logic [31:0] mk;
`ifdef CHECKER_MASK_EN
        mk = m_mask[s];
`else
        mk = 32'hFFFF_FFFF;
`endif
        return !m_wr[s] || (((m_got[s] ^ m_exp[s]) & mk) != 32'h0);
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_edges     <= 0;
            m_done_edge <= 1 << 30;
            m_phase     <= 0;
            m_slot      <= 0;
            m_err       <= 1'b0;
            m_fcnt      <= 0;
            m_ff        <= 0;
            m_fg        <= '0;
            for (int i = 0; i < NUM; i++) begin
                m_got[i]  <= '0;
                m_exp[i]  <= '0;
                m_mask[i] <= 32'hFFFF_FFFF;
                m_wr[i]   <= 1'b0;
            end
        end else begin
            m_edges <= m_edges + 1;
            if (bif.EXP_WE && int'(bif.EXP_IDX) < NUM) begin
                m_exp[bif.EXP_IDX] <= bif.EXP_DATA;
`ifdef CHECKER_MASK_EN
                m_mask[bif.EXP_IDX] <= bif.EXP_MASK;
`endif
            end
            if (m_phase == 0) begin
                if (bus_write()) begin
                    if (legal(bif.DSIZE, bif.DADDR[1:0])) begin
                        m_got[slot_of(bif.DADDR)] <= merged(m_got[slot_of(bif.DADDR)], bif.DOUT,
                                                            bif.DSIZE, bif.DADDR[1:0]);
                        m_wr[slot_of(bif.DADDR)]  <= 1'b1;
                    end else begin
                        m_err <= 1'b1;
                    end
                end
                if (full_after() || m_edges == TO - 1) begin
                    m_phase     <= 1;
                    m_slot      <= 0;
                    m_done_edge <= m_edges + 1 + NUM;
                end
            end else if (m_phase == 1) begin
                if (slot_fails(m_slot)) begin
                    m_fcnt <= m_fcnt + 1;
                    if (m_fcnt == 0) begin
                        m_ff <= m_slot;
                        m_fg <= m_got[m_slot];
                    end
                end
                if (m_slot == NUM - 1) m_phase <= 2;
                m_slot <= m_slot + 1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge CLK) begin
        if (!RESET) begin
            chk("cmp_done", 32'(bif.DONE), 32'(m_edges >= m_done_edge));
            chk("cmp_err", 32'(bif.ERR), 32'(m_err));
            if (bif.DONE) begin
                chk("cmp_pass", 32'(bif.PASS), 32'(m_fcnt == 0 && !m_err));
                chk("cmp_fail_cnt", 32'(bif.FAIL_CNT), 32'(m_fcnt));
                chk("cmp_first_fail", 32'(bif.FIRST_FAIL), 32'(m_ff));
                chk("cmp_first_got", bif.FIRST_GOT, m_fg);
            end else begin
                chk("cmp_pass_idle", 32'(bif.PASS), 32'd0);
                chk("cmp_fail_cnt_idle", 32'(bif.FAIL_CNT), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] ev(input int i);
        return 32'hC0DE_0000 | (32'(i) * 32'h0000_0111);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        bif.DREQ = 1'b1; bif.DRW = 1'b1; bif.DADDR = a; bif.DSIZE = sz; bif.DOUT = d;
        @(posedge CLK); #1;
        bif.DREQ = 1'b0; bif.DRW = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bif.DREQ = 1'b1; bif.DRW = 1'b0; bif.DADDR = a; bif.DSIZE = 2'b10; bif.DOUT = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        bif.DREQ = 1'b0;
    endtask

    task automatic ld(input int i, input logic [31:0] d, input logic [31:0] m);
        bif.EXP_WE = 1'b1; bif.EXP_IDX = IW'(i); bif.EXP_DATA = d;
`ifdef CHECKER_MASK_EN
        bif.EXP_MASK = m;
`else
        if (m == 32'h0) bif.EXP_DATA = d;
`endif
        @(posedge CLK); #1;
        bif.EXP_WE = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!bif.DONE && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("done_in_budget", 32'(bif.DONE), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, 32'(bif.DONE), 32'd0);
        chk({tag, "_pass"}, 32'(bif.PASS), 32'd0);
        chk({tag, "_fail_cnt"}, 32'(bif.FAIL_CNT), 32'd0);
        chk({tag, "_first_fail"}, 32'(bif.FIRST_FAIL), 32'd0);
        chk({tag, "_first_got"}, bif.FIRST_GOT, 32'd0);
        chk({tag, "_err"}, 32'(bif.ERR), 32'd0);
    endtask

    initial begin
        int n;
        n_tests = 0; n_fail = 0;
        RESET = 1'b1;
        bif.DREQ = 1'b0; bif.DRW = 1'b0; bif.DADDR = '0; bif.DSIZE = '0; bif.DOUT = '0;
        bif.EXP_WE = 1'b0; bif.EXP_IDX = '0; bif.EXP_DATA = '0;
`ifdef CHECKER_MASK_EN
        bif.EXP_MASK = 32'hFFFF_FFFF;
`endif

        // 1: all slots match; sweep starts on the 14th write
        do_reset();
        chk_zero("reset");
        for (int i = 0; i < NUM; i++) ld(i, ev(i), 32'hFFFF_FFFF);
        rd(BASE);
        wr(BASE - 4, 2'b10, 32'h1111_1111);
        wr(BASE + 4*NUM, 2'b10, 32'h2222_2222);
        for (int i = 0; i < NUM; i++) wr(BASE + 32'(4*i), 2'b10, ev(i));
        wait_done(40, n);
        chk("t1_latency", 32'(n), 32'd14);
        chk("t1_pass", 32'(bif.PASS), 32'd1);
        chk("t1_fail_cnt", 32'(bif.FAIL_CNT), 32'd0);

        // 2: slots 5 and 9 wrong
        do_reset();
        for (int i = 0; i < NUM; i++) ld(i, (i == 5) ? 32'hFFFF_FFFD : ev(i), 32'hFFFF_FFFF);
        for (int i = 0; i < NUM; i++)
            wr(BASE + 32'(4*i), 2'b10, (i == 5) ? 32'h0000_0002 : (i == 9) ? ev(i) ^ 32'h1 : ev(i));
        wait_done(40, n);
        chk("t2_pass", 32'(bif.PASS), 32'd0);
        chk("t2_fail_cnt", 32'(bif.FAIL_CNT), 32'd2);
        chk("t2_first_fail", 32'(bif.FIRST_FAIL), 32'd5);
        chk("t2_first_got", bif.FIRST_GOT, 32'h0000_0002);

        // 3: byte-built slot 3, half write to slot 0, expected rewrite during the sweep
        do_reset();
        for (int i = 0; i < NUM; i++)
            ld(i, (i == 0) ? 32'h0 : (i == 3) ? 32'h4433_2211 : ev(i), 32'hFFFF_FFFF);
        wr(BASE + 2, 2'b01, 32'hBEEF_1234);
        wr(BASE + 4, 2'b10, ev(1));
        wr(BASE + 8, 2'b10, ev(2));
        wr(BASE + 12, 2'b00, 32'hAAAA_AA11);
        wr(BASE + 13, 2'b00, 32'hAAAA_22AA);
        wr(BASE + 14, 2'b00, 32'hAA33_AAAA);
        wr(BASE + 15, 2'b00, 32'h44AA_AAAA);
        for (int i = 4; i < NUM; i++) wr(BASE + 32'(4*i), 2'b10, ev(i));
        ld(13, 32'hDEAD_0000, 32'hFFFF_FFFF);
        wait_done(40, n);
        chk("t3_fail_cnt", 32'(bif.FAIL_CNT), 32'd2);
        chk("t3_first_fail", 32'(bif.FIRST_FAIL), 32'd0);
        chk("t3_first_got", bif.FIRST_GOT, 32'hBEEF_0000);

        // 4: slot 13 never written, timeout forces the sweep; misaligned half sets ERR
        do_reset();
        for (int i = 0; i < NUM; i++) ld(i, ev(i), 32'hFFFF_FFFF);
        for (int i = 0; i < NUM - 1; i++) wr(BASE + 32'(4*i), 2'b10, ev(i));
        wr(BASE + 9, 2'b01, 32'h0000_5500);
        chk("t4_err_set", 32'(bif.ERR), 32'd1);
        wait_done(200, n);
        chk("t4_done_edge", 32'(m_edges), 32'(TO + NUM));
        chk("t4_fail_cnt", 32'(bif.FAIL_CNT), 32'd1);
        chk("t4_first_fail", 32'(bif.FIRST_FAIL), 32'd13);
        chk("t4_first_got", bif.FIRST_GOT, 32'd0);
        chk("t4_pass", 32'(bif.PASS), 32'd0);

        // 5: reset mid-sweep clears everything including captured data
        do_reset();
        for (int i = 0; i < NUM; i++) ld(i, ev(i), 32'hFFFF_FFFF);
        for (int i = 0; i < NUM; i++) wr(BASE + 32'(4*i), 2'b10, ev(i));
        repeat (4) @(posedge CLK);
        #1 RESET = 1'b1;
        #1 chk_zero("midreset");
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
        chk_zero("postreset");
        for (int i = 1; i < NUM; i++) wr(BASE + 32'(4*i), 2'b10, 32'h0);
        wait_done(200, n);
        chk("t5_fail_cnt", 32'(bif.FAIL_CNT), 32'd1);
        chk("t5_first_fail", 32'(bif.FIRST_FAIL), 32'd0);
        chk("t5_first_got", bif.FIRST_GOT, 32'd0);

        // 6: masked compare of slot 0
        do_reset();
        for (int i = 1; i < NUM; i++) ld(i, ev(i), 32'hFFFF_FFFF);
        ld(0, 32'h0000_0001, 32'h0000_00FF);
        wr(BASE, 2'b10, 32'hFFFF_FF01);
        for (int i = 1; i < NUM; i++) wr(BASE + 32'(4*i), 2'b10, ev(i));
        wait_done(40, n);
`ifdef CHECKER_MASK_EN
        chk("t6_pass", 32'(bif.PASS), 32'd1);
        chk("t6_fail_cnt", 32'(bif.FAIL_CNT), 32'd0);
`else
        chk("t6_pass", 32'(bif.PASS), 32'd0);
        chk("t6_fail_cnt", 32'(bif.FAIL_CNT), 32'd1);
        chk("t6_first_got", bif.FIRST_GOT, 32'hFFFF_FF01);
`endif

        @(posedge CLK); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
